// File: rtl/accel_spi_sequencer.sv
// Accelerometer SPI sequencer: powers up, writes POWER_CTL, then polls X/Y through
// an external byte engine on a sample timer or a data-ready interrupt.
module accel_spi_sequencer #(
  parameter int PWRUP_CYCLES   = 500000,
  parameter int SAMPLE_CYCLES  = 1000000,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CS_SETUP       = 2,
  parameter int CS_GAP         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int1,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  output logic       ss_n,
  output logic [7:0] accel_x,
  output logic [7:0] accel_y,
  output logic       sample_valid,
  output logic       cfg_done,
  output logic       err
);

  typedef enum logic [2:0] {PWRUP, SETUP, ISSUE, WAIT, GAP, IDLE} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [31:0] timer;
  logic [1:0]  byte_idx;
  logic        is_read;
  logic        pending;
  logic        int_s1, int_s2, int_s3;
  logic [7:0]  x_hold;
  logic        int_rise, timer_wrap, start_read, last_byte, timeout_hit, byte_done;

  function automatic logic [7:0] tx_byte(input logic rd, input logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (rd) begin
      case (idx)
        2'd0:    b = 8'h0B;
        2'd1:    b = 8'h08;
        default: b = 8'h00;
      endcase
    end else begin
      case (idx)
        2'd0:    b = 8'h0A;
        2'd1:    b = 8'h2D;
        2'd2:    b = 8'h02;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  assign int_rise    = int_s2 & ~int_s3;
  assign timer_wrap  = (timer == 32'(SAMPLE_CYCLES - 1));
  assign start_read  = (state == IDLE) && (timer_wrap || pending || int_rise);
  assign last_byte   = is_read ? (byte_idx == 2'd3) : (byte_idx == 2'd2);
  assign byte_done   = (state == WAIT) && spi_done;
  assign timeout_hit = (state == WAIT) && !spi_done && (cnt == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    spi_start = 1'b0;
    spi_tx    = 8'h00;
    case (state)
      PWRUP: if (cnt == 32'(PWRUP_CYCLES - 1)) state_nxt = SETUP;
      SETUP: if (cnt == 32'(CS_SETUP - 1)) state_nxt = ISSUE;
      ISSUE: begin
        spi_tx = tx_byte(is_read, byte_idx);
        if (!spi_busy) begin
          spi_start = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        spi_tx = tx_byte(is_read, byte_idx);
        if (spi_done)         state_nxt = last_byte ? GAP : ISSUE;
        else if (timeout_hit) state_nxt = GAP;
      end
      // A cleared cfg_done after the gap means a timeout forced reconfiguration
      GAP:   if (cnt == 32'(CS_GAP - 1)) state_nxt = cfg_done ? IDLE : SETUP;
      IDLE:  if (start_read) state_nxt = SETUP;
      default: state_nxt = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PWRUP;
      cnt          <= '0;
      timer        <= '0;
      byte_idx     <= '0;
      is_read      <= 1'b0;
      pending      <= 1'b0;
      int_s1       <= 1'b0;
      int_s2       <= 1'b0;
      int_s3       <= 1'b0;
      ss_n         <= 1'b1;
      accel_x      <= 8'h00;
      accel_y      <= 8'h00;
      sample_valid <= 1'b0;
      cfg_done     <= 1'b0;
      err          <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= (state_nxt != state) ? '0 : cnt + 32'd1;
      int_s1 <= int1;
      int_s2 <= int_s1;
      int_s3 <= int_s2;
      ss_n   <= !(state_nxt == SETUP || state_nxt == ISSUE || state_nxt == WAIT);

      // The sample period is measured from the start of the previous read
      if (!cfg_done || start_read || timer_wrap) timer <= '0;
      else                                       timer <= timer + 32'd1;

      if (start_read)                     pending <= 1'b0;
      else if (int_rise && state != IDLE) pending <= 1'b1;

      if (state != SETUP && state_nxt == SETUP) begin
        byte_idx <= '0;
        is_read  <= cfg_done;
      end else if (byte_done && !last_byte) begin
        byte_idx <= byte_idx + 2'd1;
      end

      sample_valid <= byte_done && last_byte && is_read;
      if (byte_done && last_byte && is_read) begin
        accel_x <= x_hold;
        accel_y <= spi_rx;
      end

      if (byte_done && last_byte && !is_read) cfg_done <= 1'b1;
      else if (timeout_hit)                   cfg_done <= 1'b0;

      if (timeout_hit) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_done && is_read && byte_idx == 2'd2) x_hold <= spi_rx;
  end

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Directed bench for accel_spi_sequencer with a behavioural SPI byte engine
// that answers 10 cycles after each spi_start.
module tb_accel_spi_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       int1;
  logic       spi_busy, spi_done;
  logic [7:0] spi_rx;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic       ss_n;
  logic [7:0] accel_x, accel_y;
  logic       sample_valid, cfg_done, err;

  accel_spi_sequencer #(
    .PWRUP_CYCLES(20), .SAMPLE_CYCLES(200), .TIMEOUT_CYCLES(16), .CS_SETUP(2), .CS_GAP(8)
  ) dut (
    .clk(clk), .reset(reset), .int1(int1), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_rx(spi_rx), .spi_start(spi_start), .spi_tx(spi_tx), .ss_n(ss_n),
    .accel_x(accel_x), .accel_y(accel_y), .sample_valid(sample_valid),
    .cfg_done(cfg_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Byte engine model
  logic [7:0] x_val = 8'h00;
  logic [7:0] y_val = 8'h00;
  logic       withhold_en = 1'b0;
  logic       withheld = 1'b0;

  function automatic logic [7:0] rx_tab(input int idx);
    case (idx)
      0:       return 8'hAA;
      1:       return 8'hBB;
      2:       return x_val;
      default: return y_val;
    endcase
  endfunction

  initial begin : engine
    int bidx;
    bidx     = 0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    forever begin
      @(negedge clk);
      if (ss_n) bidx = 0;
      if (spi_start) begin
        @(posedge clk);
        #1 spi_busy = 1'b1;
        if (withhold_en && !withheld && bidx == 2) begin
          withheld = 1'b1;
          for (int k = 0; k < 200 && !ss_n; k++) @(posedge clk);
          #1 spi_busy = 1'b0;
        end else begin
          repeat (9) @(posedge clk);
          #1;
          spi_done = 1'b1;
          spi_rx   = rx_tab(bidx);
          @(posedge clk);
          #1;
          spi_done = 1'b0;
          spi_busy = 1'b0;
          spi_rx   = 8'h00;
        end
        bidx++;
      end
    end
  end

  // Monitor
  int         cyc = 0;
  logic [7:0] tx_log [0:255];
  int         start_cyc [0:255];
  int         fall_cyc [0:63];
  int         gap_len [0:63];
  int         ntx = 0, nfall = 0, nvalid = 0, bad_start = 0;
  int         vld_run = 0, vld_max = 0, hi_run = 0;
  int         cfg_rise = 0, err_rise = 0;
  logic       ss_n_q = 1'b1, cfg_q = 1'b0, err_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (spi_start) begin
      if (ntx < 256) begin
        tx_log[ntx]    <= spi_tx;
        start_cyc[ntx] <= cyc;
      end
      ntx <= ntx + 1;
      if (spi_busy) bad_start <= bad_start + 1;
    end
    if (sample_valid) begin
      nvalid  <= nvalid + 1;
      vld_run <= vld_run + 1;
      if (vld_run + 1 > vld_max) vld_max <= vld_run + 1;
    end else begin
      vld_run <= 0;
    end
    ss_n_q <= ss_n;
    if (ss_n) begin
      hi_run <= hi_run + 1;
    end else begin
      if (ss_n_q) begin
        if (nfall < 64) begin
          fall_cyc[nfall] <= cyc;
          gap_len[nfall]  <= hi_run;
        end
        nfall <= nfall + 1;
      end
      hi_run <= 0;
    end
    cfg_q <= cfg_done;
    if (cfg_done && !cfg_q) cfg_rise <= cyc;
    err_q <= err;
    if (err && !err_q) err_rise <= cyc;
  end

  initial begin : main
    int rel, mark, nf0, nv0, m, n, ax, ay;
    reset = 1'b0;
    int1  = 1'b0;
    repeat (3) step();
    reset = 1'b1;

    // Reset in the middle of the first configuration byte
    for (int i = 0; i < 60 && ntx == 0; i++) step();
    check("first_start_seen", ntx > 0, 1);
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    check("rst_ss_n", ss_n, 1);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_tx", spi_tx, 8'h00);
    check("rst_accel_x", accel_x, 8'h00);
    check("rst_accel_y", accel_y, 8'h00);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_err", err, 0);
    repeat (2) step();
    reset = 1'b1;
    rel   = cyc;
    mark  = ntx;

    // Power-up and configuration write
    for (int i = 0; i < 200 && !cfg_done; i++) step();
    check("cfg_done_set", cfg_done, 1);
    check("cfg_byte_count", ntx - mark, 3);
    check("cfg_tx0", tx_log[mark], 8'h0A);
    check("cfg_tx1", tx_log[mark + 1], 8'h2D);
    check("cfg_tx2", tx_log[mark + 2], 8'h02);
    check("pwrup_wait_ge20", (start_cyc[mark] - rel) >= 20, 1);
    check("cfg_ss_n_released", ss_n, 1);

    // Two periodic reads
    x_val = 8'h12;
    y_val = 8'hFE;
    nf0   = nfall;
    nv0   = nvalid;
    mark  = ntx;
    for (int i = 0; i < 400 && nvalid == nv0; i++) step();
    check("read1_valid", sample_valid, 1);
    check("read1_tx0", tx_log[mark], 8'h0B);
    check("read1_tx1", tx_log[mark + 1], 8'h08);
    check("read1_tx2", tx_log[mark + 2], 8'h00);
    check("read1_tx3", tx_log[mark + 3], 8'h00);
    check("read1_accel_x", accel_x, 8'h12);
    check("read1_accel_y", accel_y, 8'hFE);
    check("cfg_gap_ge8", gap_len[nf0] >= 8, 1);
    step();
    check("read1_valid_one_cycle", sample_valid, 0);
    x_val = 8'h34;
    y_val = 8'h80;
    for (int i = 0; i < 300 && nvalid < nv0 + 2; i++) step();
    check("read2_accel_x", accel_x, 8'h34);
    check("read2_accel_y", accel_y, 8'h80);
    check("read_period", fall_cyc[nf0 + 1] - fall_cyc[nf0], 200);

    // Interrupt-triggered read, plus two edges collapsing into one pending read
    repeat (50) step();
    x_val = 8'h7F;
    y_val = 8'h81;
    nf0   = nfall;
    nv0   = nvalid;
    m     = cyc;
    int1  = 1'b1;
    for (int i = 0; i < 20 && nfall == nf0; i++) step();
    check("int_read_latency", (nfall > nf0) && (fall_cyc[nf0] - m >= 1) && (fall_cyc[nf0] - m <= 4), 1);
    while (cyc < m + 5)   step();
    int1 = 1'b0;
    while (cyc < m + 10)  step();
    int1 = 1'b1;
    while (cyc < m + 15)  step();
    int1 = 1'b0;
    while (cyc < m + 20)  step();
    int1 = 1'b1;
    while (cyc < m + 25)  step();
    int1 = 1'b0;
    while (cyc < m + 150) step();
    check("int_read_count", nfall - nf0, 2);
    check("int_valid_count", nvalid - nv0, 2);
    check("int_accel_x", accel_x, 8'h7F);
    check("int_accel_y", accel_y, 8'h81);
    check("pending_gap", (gap_len[nf0 + 1] >= 8) && (gap_len[nf0 + 1] <= 10), 1);

    // Withheld third byte forces a timeout
    withhold_en = 1'b1;
    nv0 = nvalid;
    ax  = accel_x;
    ay  = accel_y;
    for (int i = 0; i < 400 && !err; i++) step();
    check("timeout_err", err, 1);
    check("timeout_latency", err_rise - start_cyc[ntx - 1], 17);
    check("timeout_ss_n", ss_n, 1);
    check("timeout_cfg_done", cfg_done, 0);
    check("timeout_no_valid", nvalid - nv0, 0);
    check("timeout_accel_x", accel_x, ax);
    check("timeout_accel_y", accel_y, ay);
    mark = ntx;
    for (int i = 0; i < 100 && !cfg_done; i++) step();
    check("recfg_done", cfg_done, 1);
    check("recfg_tx0", tx_log[mark], 8'h0A);
    check("recfg_tx1", tx_log[mark + 1], 8'h2D);
    check("recfg_tx2", tx_log[mark + 2], 8'h02);
    check("recfg_err_sticky", err, 1);

    // Timer wrap and int1 edge landing in the same cycle
    n   = cfg_rise;
    nf0 = nfall;
    while (cyc < n + 197) step();
    int1 = 1'b1;
    repeat (4) step();
    int1 = 1'b0;
    while (cyc < n + 350) step();
    check("coincident_read_count", nfall - nf0, 1);
    check("coincident_read_start", fall_cyc[nf0], n + 200);
    check("no_start_while_busy", bad_start, 0);
    check("valid_max_width", vld_max, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/accel_spi_sequencer.md
Name: accel_spi_sequencer

Overview:
- Controller for the on-board SPI accelerometer path of the game display top level.
- After reset it configures the accelerometer into measurement mode, then periodically reads the X/Y acceleration bytes through an 8-bit SPI byte engine. It also reads early on a data-ready interrupt.
- It publishes the X/Y bytes with a one-cycle valid strobe for the player-position logic.
- It owns chip select and sequences the byte engine. It never touches SCLK/MOSI/MISO directly.

Parameters:
- PWRUP_CYCLES, 500000: cycles to wait after reset before first SPI access (5 ms at 100 MHz).
- SAMPLE_CYCLES, 1000000: poll period in cycles (10 ms).
- TIMEOUT_CYCLES, 1024: maximum cycles from spi_start to spi_done before abort.
- CS_SETUP, 2: cycles between ss_n falling and the first spi_start.
- CS_GAP, 8: minimum cycles ss_n stays high between transactions.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- int1  in  1  accelerometer data-ready, asynchronous; synchronized internally with 2 FFs
- spi_busy  in  1  byte engine busy
- spi_done  in  1  one-cycle pulse; spi_rx is valid in the same cycle
- spi_rx  in  8  byte received by the engine
- spi_start  out  1  one-cycle pulse requesting a byte transfer
- spi_tx  out  8  byte to send; held stable from spi_start until spi_done
- ss_n  out  1  accelerometer chip select, active low
- accel_x  out  8  last X byte (two's complement)
- accel_y  out  8  last Y byte (two's complement)
- sample_valid  out  1  one-cycle pulse when accel_x/accel_y update
- cfg_done  out  1  high once configuration has completed
- err  out  1  sticky timeout flag

Behaviour:
- Reset values (reset low, immediate, asynchronous): ss_n=1, spi_start=0, spi_tx=0x00, accel_x=0x00, accel_y=0x00, sample_valid=0, cfg_done=0, err=0, state=PWRUP, all counters 0, pending=0.
- PWRUP: count PWRUP_CYCLES, then go to CFG.
- CFG transaction (write): ss_n=0, wait CS_SETUP cycles, then send bytes 0x0A, 0x2D, 0x02 in that order. This writes POWER_CTL into measurement mode. Then RELEASE and set cfg_done=1.
- Byte issue rule: spi_start pulses for exactly one cycle, and only in a cycle where spi_busy=0. The next byte is issued no earlier than the cycle after the previous spi_done. spi_tx is held until that byte's spi_done.
- RELEASE: one cycle after the final spi_done, drive ss_n=1. Hold it high for CS_GAP cycles, then go to IDLE.
- IDLE: the sample timer counts up to SAMPLE_CYCLES-1. Start a READ when either:
  - the timer wraps, or
  - pending=1, or
  - a rising edge of the synchronized int1 is seen.
- Timer behaviour: the timer resets to 0 on entering READ. A timer wrap and an int1 edge in the same cycle start exactly one READ.
- pending flag: a rising edge of synchronized int1 outside IDLE sets pending. It is a single bit, so multiple edges collapse to one. pending is cleared when a READ starts.
- READ transaction: ss_n=0, wait CS_SETUP cycles, then send 0x0B, 0x08, 0x00, 0x00.
  - spi_rx of the 3rd byte is captured as X; spi_rx of the 4th byte as Y.
  - rx bytes of the 1st and 2nd bytes are ignored.
- Publish: in the cycle after the 4th spi_done, accel_x/accel_y update together and sample_valid=1 for that one cycle. Then RELEASE and back to IDLE.
- Timeout: if spi_done has not arrived TIMEOUT_CYCLES cycles after a spi_start:
  - ss_n=1 next cycle, err=1 (sticky until reset), cfg_done=0;
  - no publish; accel_x/accel_y keep their old values;
  - after the CS_GAP hold, restart at CFG (PWRUP is not repeated).
- A spi_done arriving in a state that is not waiting for one is ignored.
- Reset asserted mid-transaction: ss_n goes high asynchronously and any byte in flight is abandoned. After release, the full sequence restarts at PWRUP.
- Latency at default parameters: from the timer wrap, the first spi_start follows after CS_SETUP+1 cycles; the publish is 1 cycle after the last spi_done.

Test Plan (bench uses PWRUP_CYCLES=20, SAMPLE_CYCLES=200, TIMEOUT_CYCLES=16; the byte-engine model answers 10 cycles after spi_start):
1. Reset low with the design mid-run -> ss_n=1, spi_start=0, outputs 0x00, cfg_done=0, err=0 immediately. Release -> no spi_start before cycle 20.
2. Power-up -> ss_n falls, then tx sequence exactly 0x0A, 0x2D, 0x02. Then ss_n rises, stays high ≥8 cycles, and cfg_done=1.
3. Periodic read with model returning 0xAA, 0xBB, 0x12, 0xFE -> tx 0x0B, 0x08, 0x00, 0x00; accel_x=0x12, accel_y=0xFE; sample_valid high exactly 1 cycle. Next read starts 200 cycles after this read began.
4. int1 rising edge in IDLE 50 cycles after a read -> read starts within 4 cycles. Two int1 edges during a transaction -> exactly one extra read after the CS_GAP hold.
5. Model withholds spi_done on the 3rd read byte -> 16 cycles later ss_n=1, err=1, cfg_done=0, no sample_valid, accel_x/accel_y unchanged. A config transaction then repeats, and err stays 1.
6. Timer wrap coincident with an int1 edge -> exactly one read transaction; no spi_start is ever issued while spi_busy=1.
